// File: rtl/tlb_op_ctrl.sv
// tlb_op_ctrl: sequences the MIPS TLB instructions (TLBP, TLBR, TLBWI, TLBWR)
// and maintains the CP0 Random register.
//
// Handshake: a request is taken on the cycle where op_valid && op_ready.
// op_ready is high only in IDLE. The requester holds op_valid (and op_type)
// until it sees op_ready. Nothing is queued. The request is acknowledged by a
// one-cycle done pulse.
//
// TLBNUM must equal 2**IDXW.
module tlb_op_ctrl #(
    parameter int TLBNUM = 32,
    parameter int IDXW   = 5
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            op_valid,
    input  logic [1:0]      op_type,
    output logic            op_ready,
    input  logic [IDXW-1:0] cp0_index,
    input  logic [IDXW-1:0] cp0_wired,
    input  logic            wired_we,
    output logic            wtlbe,
    output logic [IDXW-1:0] wtlb_addr,
    input  logic            wtlb_finish,
    input  logic            pmatch_true,
    input  logic [IDXW-1:0] p_index,
    output logic [IDXW-1:0] r_index,
    output logic            rd_load,
    output logic            done,
    output logic            probe_miss,
    output logic [IDXW-1:0] res_index,
    output logic            pipe_flush,
    output logic [IDXW-1:0] random,
    output logic [2:0]      fsm_state
);

    typedef enum logic [2:0] {
        IDLE     = 3'd0,
        PROBE    = 3'd1,
        READ     = 3'd2,
        WRITE    = 3'd3,
        WAIT_FIN = 3'd4,
        DONE     = 3'd5
    } state_t;

    localparam logic [1:0] OP_TLBP  = 2'b00;
    localparam logic [1:0] OP_TLBR  = 2'b01;
    localparam logic [1:0] OP_TLBWR = 2'b11;

    localparam logic [IDXW-1:0] TOP_IDX = IDXW'(TLBNUM - 1);

    state_t          state_q;
    state_t          state_d;
    logic [1:0]      op_q;
    logic [IDXW-1:0] idx_q;
    logic            accept;

    assign accept = op_valid && (state_q == IDLE);

    // State register; reset aborts any operation in flight.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic: dispatch on accept, single-cycle action states,
    // WAIT_FIN holds until the TLB reports the write complete.
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE: begin
                if (accept) begin
                    case (op_type)
                        OP_TLBP: state_d = PROBE;
                        OP_TLBR: state_d = READ;
                        default: state_d = WRITE;
                    endcase
                end
            end
            PROBE:    state_d = DONE;
            READ:     state_d = DONE;
            WRITE:    state_d = WAIT_FIN;
            WAIT_FIN: if (wtlb_finish) state_d = DONE;
            DONE:     state_d = IDLE;
            default:  state_d = IDLE;
        endcase
    end

    // Latch the operation and its target index at accept. TLBWR snapshots
    // Random here so later Random updates cannot move the write.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            op_q  <= 2'b00;
            idx_q <= '0;
        end else if (accept) begin
            op_q  <= op_type;
            idx_q <= (op_type == OP_TLBWR) ? random : cp0_index;
        end
    end

    // Read index is loaded on entry to READ so it is valid while rd_load is
    // high, and holds afterwards.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_index <= '0;
        end else if (accept && (op_type == OP_TLBR)) begin
            r_index <= cp0_index;
        end
    end

    // Probe result captured from the TLB during PROBE; holds until the next TLBP.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            probe_miss <= 1'b0;
            res_index  <= '0;
        end else if (state_q == PROBE) begin
            probe_miss <= !pmatch_true;
            res_index  <= pmatch_true ? p_index : '0;
        end
    end

    // Random counts down each cycle from TLBNUM-1 to Wired, then reloads.
    // A Wired write forces the reload; a Wired at or above the top pins it.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            random <= TOP_IDX;
        end else if (wired_we) begin
            random <= TOP_IDX;
        end else if (cp0_wired >= TOP_IDX) begin
            random <= TOP_IDX;
        end else if (random == cp0_wired) begin
            random <= TOP_IDX;
        end else begin
            random <= random - IDXW'(1);
        end
    end

    assign op_ready   = (state_q == IDLE);
    assign wtlbe      = (state_q == WRITE);
    assign wtlb_addr  = idx_q;
    assign rd_load    = (state_q == READ);
    assign done       = (state_q == DONE);
    assign pipe_flush = (state_q == DONE) && op_q[1];
    assign fsm_state  = state_q;

endmodule

// File: tb/tb_tlb_op_ctrl.sv
// Directed testbench for tlb_op_ctrl.
module tb_tlb_op_ctrl;

    localparam int IDXW = 5;

    localparam logic [2:0] ST_IDLE     = 3'd0;
    localparam logic [2:0] ST_PROBE    = 3'd1;
    localparam logic [2:0] ST_READ     = 3'd2;
    localparam logic [2:0] ST_WRITE    = 3'd3;
    localparam logic [2:0] ST_WAIT_FIN = 3'd4;
    localparam logic [2:0] ST_DONE     = 3'd5;

    logic            clk = 1'b0;
    logic            rst;
    logic            op_valid;
    logic [1:0]      op_type;
    logic            op_ready;
    logic [IDXW-1:0] cp0_index;
    logic [IDXW-1:0] cp0_wired;
    logic            wired_we;
    logic            wtlbe;
    logic [IDXW-1:0] wtlb_addr;
    logic            wtlb_finish;
    logic            pmatch_true;
    logic [IDXW-1:0] p_index;
    logic [IDXW-1:0] r_index;
    logic            rd_load;
    logic            done;
    logic            probe_miss;
    logic [IDXW-1:0] res_index;
    logic            pipe_flush;
    logic [IDXW-1:0] random;
    logic [2:0]      fsm_state;

    int n_checks = 0;
    int n_fail   = 0;

    logic [IDXW-1:0] exp_q[$];

    tlb_op_ctrl #(.TLBNUM(32), .IDXW(IDXW)) dut (
        .clk         (clk),
        .rst         (rst),
        .op_valid    (op_valid),
        .op_type     (op_type),
        .op_ready    (op_ready),
        .cp0_index   (cp0_index),
        .cp0_wired   (cp0_wired),
        .wired_we    (wired_we),
        .wtlbe       (wtlbe),
        .wtlb_addr   (wtlb_addr),
        .wtlb_finish (wtlb_finish),
        .pmatch_true (pmatch_true),
        .p_index     (p_index),
        .r_index     (r_index),
        .rd_load     (rd_load),
        .done        (done),
        .probe_miss  (probe_miss),
        .res_index   (res_index),
        .pipe_flush  (pipe_flush),
        .random      (random),
        .fsm_state   (fsm_state)
    );

    // Clock
    always #5 clk = ~clk;

    // Watchdog
    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
        end
    endtask

    // Advance one clock and sample just after the edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check_reset_outputs(input string tag);
        check_eq({tag, "_op_ready"},   32'(op_ready),   1);
        check_eq({tag, "_wtlbe"},      32'(wtlbe),      0);
        check_eq({tag, "_rd_load"},    32'(rd_load),    0);
        check_eq({tag, "_done"},       32'(done),       0);
        check_eq({tag, "_pipe_flush"}, 32'(pipe_flush), 0);
        check_eq({tag, "_probe_miss"}, 32'(probe_miss), 0);
        check_eq({tag, "_res_index"},  32'(res_index),  0);
        check_eq({tag, "_r_index"},    32'(r_index),    0);
        check_eq({tag, "_wtlb_addr"},  32'(wtlb_addr),  0);
        check_eq({tag, "_random"},     32'(random),     31);
        check_eq({tag, "_state"},      32'(fsm_state),  32'(ST_IDLE));
    endtask

    initial begin
        int i;
        logic [IDXW-1:0] e;

        rst         = 1'b1;
        op_valid    = 1'b0;
        op_type     = 2'b00;
        cp0_index   = '0;
        cp0_wired   = 5'd4;
        wired_we    = 1'b0;
        wtlb_finish = 1'b0;
        pmatch_true = 1'b0;
        p_index     = '0;

        // Reset block
        tick();
        tick();
        check_reset_outputs("reset");
        rst = 1'b0;

        // Random with Wired=4: 31 down to 4, then 31 again (41 samples).
        e = 5'd31;
        for (int k = 0; k <= 40; k++) begin
            exp_q.push_back(e);
            e = (e == 5'd4) ? 5'd31 : e - 5'd1;
        end
        for (int k = 0; k <= 40; k++) begin
            if (k > 0) tick();
            check_eq($sformatf("rand_seq_%0d", k), 32'(random), 32'(exp_q.pop_front()));
        end

        // random is 19 here; a Wired write forces 31, then it counts on.
        wired_we = 1'b1;
        tick();
        wired_we = 1'b0;
        check_eq("rand_wired_we", 32'(random), 31);
        tick();
        check_eq("rand_after_wired_we", 32'(random), 30);

        // Wrap and Wired write together still give 31.
        i = 0;
        while (random != 5'd4 && i < 64) begin
            tick();
            i++;
        end
        check_eq("rand_reach_4", 32'(random), 4);
        wired_we = 1'b1;
        tick();
        wired_we = 1'b0;
        check_eq("rand_wrap_and_we", 32'(random), 31);

        // Wired at the top pins Random at 31.
        cp0_wired = 5'd31;
        tick();
        check_eq("rand_pin_1", 32'(random), 31);
        tick();
        tick();
        check_eq("rand_pin_3", 32'(random), 31);
        cp0_wired = 5'd4;
        tick();
        check_eq("rand_resume", 32'(random), 30);

        // TLBWR accepted when random is 9.
        i = 0;
        while (random != 5'd9 && i < 64) begin
            tick();
            i++;
        end
        check_eq("tlbwr_reach_9", 32'(random), 9);
        cp0_index = 5'd20;
        op_valid  = 1'b1;
        op_type   = 2'b11;
        tick();
        op_valid = 1'b0;
        check_eq("tlbwr_state_write", 32'(fsm_state), 32'(ST_WRITE));
        check_eq("tlbwr_wtlbe", 32'(wtlbe), 1);
        check_eq("tlbwr_addr", 32'(wtlb_addr), 9);
        check_eq("tlbwr_rand_moved", 32'(random), 8);
        tick();
        check_eq("tlbwr_wait_wtlbe", 32'(wtlbe), 0);
        check_eq("tlbwr_wait_addr", 32'(wtlb_addr), 9);
        wtlb_finish = 1'b1;
        tick();
        wtlb_finish = 1'b0;
        check_eq("tlbwr_done", 32'(done), 1);
        check_eq("tlbwr_flush", 32'(pipe_flush), 1);
        tick();
        check_eq("tlbwr_idle", 32'(op_ready), 1);
        check_eq("tlbwr_done_clr", 32'(done), 0);

        // TLBP hit at index 7.
        op_valid    = 1'b1;
        op_type     = 2'b00;
        pmatch_true = 1'b1;
        p_index     = 5'd7;
        tick();
        op_valid = 1'b0;
        check_eq("tlbp_hit_state", 32'(fsm_state), 32'(ST_PROBE));
        check_eq("tlbp_hit_ready", 32'(op_ready), 0);
        check_eq("tlbp_hit_nodone", 32'(done), 0);
        tick();
        pmatch_true = 1'b0;
        p_index     = 5'd0;
        check_eq("tlbp_hit_done", 32'(done), 1);
        check_eq("tlbp_hit_miss", 32'(probe_miss), 0);
        check_eq("tlbp_hit_index", 32'(res_index), 7);
        check_eq("tlbp_hit_flush", 32'(pipe_flush), 0);
        tick();
        check_eq("tlbp_hit_done_clr", 32'(done), 0);
        check_eq("tlbp_hit_hold", 32'(res_index), 7);

        // TLBP miss.
        op_valid    = 1'b1;
        op_type     = 2'b00;
        pmatch_true = 1'b0;
        p_index     = 5'd9;
        tick();
        op_valid = 1'b0;
        tick();
        check_eq("tlbp_miss_done", 32'(done), 1);
        check_eq("tlbp_miss_flag", 32'(probe_miss), 1);
        check_eq("tlbp_miss_index", 32'(res_index), 0);
        tick();
        check_eq("tlbp_miss_hold", 32'(probe_miss), 1);

        // TLBR at index 3, with a TLBWI request held during READ.
        cp0_index = 5'd3;
        op_valid  = 1'b1;
        op_type   = 2'b01;
        tick();
        op_type = 2'b10;
        check_eq("tlbr_state", 32'(fsm_state), 32'(ST_READ));
        check_eq("tlbr_rd_load", 32'(rd_load), 1);
        check_eq("tlbr_r_index", 32'(r_index), 3);
        check_eq("tlbr_ready", 32'(op_ready), 0);
        tick();
        cp0_index = 5'd12;
        check_eq("tlbr_done", 32'(done), 1);
        check_eq("tlbr_rd_load_clr", 32'(rd_load), 0);
        check_eq("tlbr_flush", 32'(pipe_flush), 0);
        check_eq("tlbr_no_accept_wtlbe", 32'(wtlbe), 0);
        tick();
        check_eq("tlbr_back_idle", 32'(fsm_state), 32'(ST_IDLE));
        check_eq("tlbr_r_index_hold", 32'(r_index), 3);

        // The held TLBWI is accepted now, index 12.
        tick();
        op_valid = 1'b0;
        check_eq("tlbwi_wtlbe", 32'(wtlbe), 1);
        check_eq("tlbwi_addr", 32'(wtlb_addr), 12);
        tick();
        check_eq("tlbwi_wait_state", 32'(fsm_state), 32'(ST_WAIT_FIN));
        for (int k = 0; k < 3; k++) begin
            tick();
            check_eq($sformatf("tlbwi_wait_%0d_wtlbe", k), 32'(wtlbe), 0);
            check_eq($sformatf("tlbwi_wait_%0d_done", k), 32'(done), 0);
        end
        wtlb_finish = 1'b1;
        tick();
        wtlb_finish = 1'b0;
        check_eq("tlbwi_done", 32'(done), 1);
        check_eq("tlbwi_flush", 32'(pipe_flush), 1);
        check_eq("tlbwi_no_second_wtlbe", 32'(wtlbe), 0);
        tick();
        check_eq("tlbwi_idle", 32'(op_ready), 1);

        // wtlb_finish outside WAIT_FIN is ignored.
        wtlb_finish = 1'b1;
        tick();
        wtlb_finish = 1'b0;
        check_eq("fin_idle_state", 32'(fsm_state), 32'(ST_IDLE));
        check_eq("fin_idle_done", 32'(done), 0);

        // Reset while in WAIT_FIN.
        op_valid = 1'b1;
        op_type  = 2'b10;
        tick();
        op_valid = 1'b0;
        tick();
        check_eq("rst_mid_wait_state", 32'(fsm_state), 32'(ST_WAIT_FIN));
        rst = 1'b1;
        #1;
        check_reset_outputs("rst_mid");
        tick();
        rst = 1'b0;
        wtlb_finish = 1'b1;
        tick();
        wtlb_finish = 1'b0;
        check_eq("rst_after_done", 32'(done), 0);
        check_eq("rst_after_state", 32'(fsm_state), 32'(ST_IDLE));
        check_eq("rst_after_wtlbe", 32'(wtlbe), 0);
        tick();
        check_eq("rst_after_done2", 32'(done), 0);

        // Final report
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
